ldpc_3gpp_dec_hb_seq: RTL and testbench
=======================================

Name: ldpc_3gpp_dec_hb_seq

Overview:
Row scheduler for the fixed-mode 3GPP LDPC decoder base-matrix tables. Per codeword it generates the read-row address stream (irrow of the Hb table) for every decoding iteration. It also generates the matching write-back row stream (iwrow), delayed by the node-processing pipeline latency. It handles the iteration count, inter-iteration hazard gaps, early termination, pipeline drain and the done handshake.

Parameters:
pROW_W, 6, width of row index (covers 46 Hb row groups)
pITER_W, 5, width of iteration count/index
pPIPE_LAT, 4, read-to-write latency in enabled cycles (legal range >=1)
pITER_GAP, 2, idle enabled cycles inserted between iterations (legal range >=0)

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous active-high reset
iclkena  in  1  clock enable; all state, counters and the write delay line advance only when 1
istart  in  1  start request; accepted only when ordy=1
iNiter  in  pITER_W  iterations; sampled at accept; 0 is treated as 1
iused_row  in  pROW_W  row groups per iteration (table oused_row); sampled at accept; 0 is treated as 1
iearly_stop  in  1  syndrome-OK flag; sampled on enabled cycles where ordval & olast_row
ordy  out  1  idle, ready for istart
obusy  out  1  equals ~ordy
orrow  out  pROW_W  read row address (to table irrow)
ordval  out  1  orrow valid
ofirst_row  out  1  orrow==0 and ordval
olast_row  out  1  orrow==used_row-1 and ordval
oiter  out  pITER_W  iteration index of the current read row
owrow  out  pROW_W  write row address (to table iwrow)
owval  out  1  owrow valid
odone  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE, ordy=1, obusy=0, orrow=0, ordval=0, ofirst_row=0, olast_row=0, oiter=0, owrow=0, owval=0, odone=0. The delay line is cleared.
- All outputs are registered.
- The reset is asynchronous and can occur in any state, including mid-operation. It forces the reset values immediately and aborts the codeword with no odone.
- FSM states: IDLE, RUN, GAP, DRAIN.
- IDLE:
  - On an enabled edge with istart=1, latch Niter and used_row, then go to RUN.
  - On that same edge, set orrow=0, ordval=1, oiter=0 and ordy=0.
- RUN:
  - Each enabled edge advances orrow by 1.
  - When the row just issued is used_row-1, the last-iteration test applies. The iteration is the last if oiter==Niter-1 or if iearly_stop was sampled as 1 on that cycle.
  - Last iteration: go to DRAIN with ordval=0.
  - Otherwise, with pITER_GAP>0: go to GAP with ordval=0.
  - Otherwise, with pITER_GAP==0: stay in RUN with orrow=0 and oiter+1. There is no bubble.
- GAP: hold ordval=0 for exactly pITER_GAP enabled cycles, then go to RUN with orrow=0 and oiter+1.
- DRAIN:
  - Wait until the delay line holds no valid entry.
  - On the enabled edge after the final owval cycle, assert odone=1 and ordy=1, and return to IDLE.
  - odone is high for one enabled cycle; if iclkena is low it holds until the next enabled edge.
- Write stream: {owval, owrow} equals {ordval, orrow} delayed by exactly pPIPE_LAT enabled cycles (a shift register).
- istart while busy is ignored and has no side effect. istart in the same cycle that odone is asserted is accepted, because ordy=1 in that cycle.
- iclkena=0: every register holds, including the outputs and the gap/drain counters. The latency is counted in enabled cycles only.
- iearly_stop is ignored in all cycles other than the last-row cycle.
- The last-row cycle of the final permitted iteration ends the run whether or not early stop is asserted.
- Counter widths: the row counter is pROW_W bits and the iteration counter is pITER_W bits. Neither wraps within legal operation.
- Latency (iclkena=1, pPIPE_LAT=L, pITER_GAP=G, used_row=R, iterations run N):
  - The first ordval appears 1 cycle after istart.
  - odone appears N*R + (N-1)*G + L + 1 cycles after istart.

Test Plan:
- Single iteration, R=4, N=1, L=4, G=2, istart at cycle 0 -> ordval cycles 1-4 with orrow 0,1,2,3; owval cycles 5-8 with the same rows; odone at cycle 9; ordy=1 from cycle 9.
- Two iterations, R=3, N=2, L=4, G=2 -> ordval cycles 1-3 and 6-8; oiter=1 in cycles 6-8; owval cycles 5-7 and 10-12; odone at cycle 13.
- Early stop, R=3, N=5, iearly_stop=1 only on the last row of iteration 1 -> no iteration-2 reads; odone at 2*3+2+4+1 = cycle 13. iearly_stop pulsed on a non-last row -> ignored.
- iclkena toggling 1/0 every other cycle, R=2, N=1 -> same orrow/owrow sequences; every output stable in disabled cycles; odone after 1*2+4+1 = 7 enabled cycles.
- Reset asserted during RUN at row 1 -> all outputs take reset values immediately; no odone; a new istart gives ordval 1 cycle after accept.
- Corner cases:
  - iNiter=0 and iused_row=0 -> treated as 1/1: a single read of row 0; odone at 1+1+L = cycle 6 (L=4).
  - istart pulses while busy -> ignored.
  - istart coincident with odone -> new run starts; ordval appears the next cycle.

Source files
------------

// File: rtl/ldpc_3gpp_dec_hb_seq.sv
// Row scheduler for the fixed-mode 3GPP LDPC decoder: emits the per-iteration read-row
// stream, a latency-matched write-row stream, and a done pulse once the pipeline drains.
module ldpc_3gpp_dec_hb_seq #(
    parameter int pROW_W    = 6,
    parameter int pITER_W   = 5,
    parameter int pPIPE_LAT = 4,
    parameter int pITER_GAP = 2
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               istart,
    input  logic [pITER_W-1:0] iNiter,
    input  logic [pROW_W-1:0]  iused_row,
    input  logic               iearly_stop,
    output logic               ordy,
    output logic               obusy,
    output logic [pROW_W-1:0]  orrow,
    output logic               ordval,
    output logic               ofirst_row,
    output logic               olast_row,
    output logic [pITER_W-1:0] oiter,
    output logic [pROW_W-1:0]  owrow,
    output logic               owval,
    output logic               odone
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam int         GAP_W   = (pITER_GAP > 1) ? $clog2(pITER_GAP) : 1;

    logic [1:0]         state;
    logic [pITER_W-1:0] niter_q;
    logic [pROW_W-1:0]  used_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic               dl_val [pPIPE_LAT];
    logic [pROW_W-1:0]  dl_row [pPIPE_LAT];
    logic               pend;

    // Last stage of the delay line is the write-stream output register.
    assign owval = dl_val[pPIPE_LAT-1];
    assign owrow = dl_row[pPIPE_LAT-1];

    // Anything that will still reach the write stream after this edge.
    always_comb begin
        pend = ordval;
        for (int i = 0; i < pPIPE_LAT - 1; i++) pend = pend | dl_val[i];
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state      <= S_IDLE;
            niter_q    <= '0;
            used_q     <= '0;
            gap_cnt    <= '0;
            ordy       <= 1'b1;
            obusy      <= 1'b0;
            orrow      <= '0;
            ordval     <= 1'b0;
            ofirst_row <= 1'b0;
            olast_row  <= 1'b0;
            oiter      <= '0;
            odone      <= 1'b0;
            for (int i = 0; i < pPIPE_LAT; i++) begin
                dl_val[i] <= 1'b0;
                dl_row[i] <= '0;
            end
        end else if (iclkena) begin
            dl_val[0] <= ordval;
            dl_row[0] <= orrow;
            for (int i = 1; i < pPIPE_LAT; i++) begin
                dl_val[i] <= dl_val[i-1];
                dl_row[i] <= dl_row[i-1];
            end
            odone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (istart) begin
                        niter_q    <= (iNiter == '0) ? pITER_W'(1) : iNiter;
                        used_q     <= (iused_row == '0) ? pROW_W'(1) : iused_row;
                        orrow      <= '0;
                        ordval     <= 1'b1;
                        ofirst_row <= 1'b1;
                        olast_row  <= (iused_row <= pROW_W'(1));
                        oiter      <= '0;
                        ordy       <= 1'b0;
                        obusy      <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (olast_row) begin
                        if ((oiter == niter_q - pITER_W'(1)) || iearly_stop) begin
                            orrow      <= '0;
                            ordval     <= 1'b0;
                            ofirst_row <= 1'b0;
                            olast_row  <= 1'b0;
                            state      <= S_DRAIN;
                        end else if (pITER_GAP > 0) begin
                            orrow      <= '0;
                            ordval     <= 1'b0;
                            ofirst_row <= 1'b0;
                            olast_row  <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= S_GAP;
                        end else begin
                            orrow      <= '0;
                            ofirst_row <= 1'b1;
                            olast_row  <= (used_q == pROW_W'(1));
                            oiter      <= oiter + pITER_W'(1);
                        end
                    end else begin
                        orrow      <= orrow + pROW_W'(1);
                        ofirst_row <= 1'b0;
                        olast_row  <= (orrow + pROW_W'(1) == used_q - pROW_W'(1));
                    end
                end
                S_GAP: begin
                    if (int'(gap_cnt) == pITER_GAP - 1) begin
                        orrow      <= '0;
                        ordval     <= 1'b1;
                        ofirst_row <= 1'b1;
                        olast_row  <= (used_q == pROW_W'(1));
                        oiter      <= oiter + pITER_W'(1);
                        state      <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    if (!pend) begin
                        odone <= 1'b1;
                        ordy  <= 1'b1;
                        obusy <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_hb_seq.sv
// Directed bench for the LDPC row scheduler: per-cycle capture against hand-built
// expected waveforms for each scenario (L=4, G=2 defaults).
module tb_ldpc_3gpp_dec_hb_seq;
    localparam int RW = 6;
    localparam int IW = 5;

    logic          iclk = 1'b0;
    logic          ireset = 1'b1;
    logic          iclkena = 1'b1;
    logic          istart = 1'b0;
    logic [IW-1:0] iNiter = 5'd1;
    logic [RW-1:0] iused_row = 6'd1;
    logic          iearly_stop = 1'b0;
    logic          ordy, obusy, ordval, ofirst_row, olast_row, owval, odone;
    logic [RW-1:0] orrow, owrow;
    logic [IW-1:0] oiter;

    int n_tests = 0;
    int n_fail  = 0;

    logic          c_rv[64], c_fs[64], c_ls[64], c_wv[64], c_dn[64], c_rdy[64], c_bsy[64];
    logic [RW-1:0] c_rr[64], c_wr[64];
    logic [IW-1:0] c_it[64];
    logic          e_rv[64], e_fs[64], e_ls[64], e_wv[64], e_dn[64], e_rdy[64];
    logic [RW-1:0] e_rr[64], e_wr[64];
    logic [IW-1:0] e_it[64];
    logic [23:0]   obs, exp_v;

    ldpc_3gpp_dec_hb_seq dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
        .iNiter(iNiter), .iused_row(iused_row), .iearly_stop(iearly_stop),
        .ordy(ordy), .obusy(obusy), .orrow(orrow), .ordval(ordval),
        .ofirst_row(ofirst_row), .olast_row(olast_row), .oiter(oiter),
        .owrow(owrow), .owval(owval), .odone(odone)
    );

    always #5 iclk = ~iclk;

    task automatic clear_exp();
        for (int k = 0; k < 64; k++) begin
            e_rv[k] = 0; e_fs[k] = 0; e_ls[k] = 0; e_wv[k] = 0; e_dn[k] = 0;
            e_rdy[k] = 1; e_rr[k] = '0; e_wr[k] = '0; e_it[k] = '0;
        end
    endtask

    task automatic rseg(input int s, input int len, input int it);
        for (int j = 0; j < len; j++) begin
            e_rv[s+j] = 1; e_rr[s+j] = RW'(j); e_it[s+j] = IW'(it);
            e_fs[s+j] = (j == 0); e_ls[s+j] = (j == len - 1);
        end
    endtask

    task automatic wseg(input int s, input int len);
        for (int j = 0; j < len; j++) begin
            e_wv[s+j] = 1; e_wr[s+j] = RW'(j);
        end
    endtask

    task automatic busy(input int a, input int b);
        for (int k = a; k <= b; k++) e_rdy[k] = 0;
    endtask

    // Entered and left just after a rising edge; cycle k's outputs are sampled here.
    task automatic run_cycles(input int n, input logic [63:0] st, input logic [63:0] es,
                              input logic [63:0] en);
        for (int k = 0; k < n; k++) begin
            istart = st[k]; iearly_stop = es[k]; iclkena = en[k];
            c_rv[k] = ordval; c_rr[k] = orrow; c_it[k] = oiter; c_fs[k] = ofirst_row;
            c_ls[k] = olast_row; c_wv[k] = owval; c_wr[k] = owrow; c_dn[k] = odone;
            c_rdy[k] = ordy; c_bsy[k] = obusy;
            @(posedge iclk); #1;
        end
        istart = 0; iearly_stop = 0; iclkena = 1;
    endtask

    function automatic logic [23:0] pack_obs(input int k);
        return {c_rv[k], c_rv[k] ? c_rr[k] : 6'd0, c_rv[k] ? c_it[k] : 5'd0, c_fs[k], c_ls[k],
                c_wv[k], c_wv[k] ? c_wr[k] : 6'd0, c_dn[k], c_rdy[k], c_bsy[k]};
    endfunction

    function automatic logic [23:0] pack_exp(input int k);
        return {e_rv[k], e_rv[k] ? e_rr[k] : 6'd0, e_rv[k] ? e_it[k] : 5'd0, e_fs[k], e_ls[k],
                e_wv[k], e_wv[k] ? e_wr[k] : 6'd0, e_dn[k], e_rdy[k], ~e_rdy[k]};
    endfunction

    task automatic test_reset();
        @(posedge iclk); #1;
        n_tests++;
        obs = {ordy, obusy, orrow, ordval, ofirst_row, olast_row, oiter, owrow, owval, odone};
        if (obs !== 24'h80_0000) begin
            n_fail++; $display("FAIL reset_values got %h exp %h", obs, 24'h80_0000);
        end
        ireset = 0;
    endtask

    // R=4, N=1, with istart pulses while busy that must be ignored.
    task automatic test_single();
        iNiter = 5'd1; iused_row = 6'd4;
        clear_exp(); rseg(1, 4, 0); wseg(5, 4); e_dn[9] = 1; busy(1, 8);
        run_cycles(12, 64'h89, 64'h0, '1);
        for (int k = 0; k < 12; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL single cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    // R=3, N=2; istart in a gap cycle ignored, istart on the odone cycle restarts.
    task automatic test_back_to_back();
        iNiter = 5'd2; iused_row = 6'd3;
        clear_exp();
        rseg(1, 3, 0); rseg(6, 3, 1); rseg(14, 3, 0); rseg(19, 3, 1);
        wseg(5, 3); wseg(10, 3); wseg(18, 3); wseg(23, 3);
        e_dn[13] = 1; e_dn[26] = 1; busy(1, 12); busy(14, 25);
        run_cycles(29, 64'h2021, 64'h0, '1);
        for (int k = 0; k < 29; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL back_to_back cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    // R=3, N=5; early stop on a middle row and in a gap is ignored, on iteration 1's last row ends.
    task automatic test_early_stop();
        iNiter = 5'd5; iused_row = 6'd3;
        clear_exp(); rseg(1, 3, 0); rseg(6, 3, 1); wseg(5, 3); wseg(10, 3);
        e_dn[13] = 1; busy(1, 12);
        run_cycles(18, 64'h1, 64'h114, '1);
        for (int k = 0; k < 18; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL early_stop cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    // R=2, N=1 with iclkena high only on even cycles: every value lasts two cycles.
    task automatic test_clkena();
        iNiter = 5'd1; iused_row = 6'd2;
        clear_exp();
        for (int j = 0; j < 2; j++) begin
            e_rv[1+j] = 1; e_rr[1+j] = 6'd0; e_fs[1+j] = 1;
            e_rv[3+j] = 1; e_rr[3+j] = 6'd1; e_ls[3+j] = 1;
            e_wv[9+j] = 1; e_wr[9+j] = 6'd0;
            e_wv[11+j] = 1; e_wr[11+j] = 6'd1;
            e_dn[13+j] = 1;
        end
        busy(1, 12);
        run_cycles(18, 64'h1, 64'h0, 64'h5555_5555_5555_5555);
        for (int k = 0; k < 18; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL clkena cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    // iNiter=0 and iused_row=0 behave as 1/1.
    task automatic test_zero_params();
        iNiter = 5'd0; iused_row = 6'd0;
        clear_exp(); rseg(1, 1, 0); wseg(5, 1); e_dn[6] = 1; busy(1, 5);
        run_cycles(9, 64'h1, 64'h0, '1);
        for (int k = 0; k < 9; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL zero_params cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        iNiter = 5'd3; iused_row = 6'd4;
        run_cycles(2, 64'h1, 64'h0, '1);
        n_tests++;
        if ({ordval, orrow} !== {1'b1, 6'd1}) begin
            n_fail++; $display("FAIL mid_run_row got %b/%0d exp 1/1", ordval, orrow);
        end
        #2 ireset = 1;
        #1;
        n_tests++;
        obs = {ordy, obusy, orrow, ordval, ofirst_row, olast_row, oiter, owrow, owval, odone};
        if (obs !== 24'h80_0000) begin
            n_fail++; $display("FAIL mid_reset_values got %h exp %h", obs, 24'h80_0000);
        end
        @(posedge iclk); #1;
        ireset = 0;
        clear_exp();
        run_cycles(10, 64'h0, 64'h0, '1);
        for (int k = 0; k < 10; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL post_reset_idle cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
        iNiter = 5'd1; iused_row = 6'd2;
        clear_exp(); rseg(1, 2, 0); wseg(5, 2); e_dn[7] = 1; busy(1, 6);
        run_cycles(9, 64'h1, 64'h0, '1);
        for (int k = 0; k < 9; k++) begin
            n_tests++; obs = pack_obs(k); exp_v = pack_exp(k);
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL restart cycle %0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_early_stop();
        test_clkena();
        test_zero_params();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
